// File: rtl/univ_shift_seq.sv
// Sequential universal shift register: multi-position shift/rotate executed one
// bit per cycle, with start/busy/done handshake, parallel load and serial in/out.
module univ_shift_seq #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          load,
  input  logic [N-1:0]  d,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          sin,
  output logic [N-1:0]  q,
  output logic          sout,
  output logic          busy,
  output logic          done,
  output logic          dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          sout_q, sout_d;
  logic          done_q, done_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    m_q, m_d;

  // Handshake: start is taken only in IDLE with en high; busy stays high for
  // the whole SHIFT phase and done pulses for one cycle after the last step.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    m_d     = m_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (load) begin
            q_d = d;
          end else if (start) begin
            if (amt != '0) begin
              m_d     = mode;
              cnt_d   = amt;
              state_d = SHIFT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          case (m_q)
            3'd0: begin q_d = {1'b0, q_q[N-1:1]};        sout_d = q_q[0];   end
            3'd1: begin q_d = {q_q[N-2:0], 1'b0};        sout_d = q_q[N-1]; end
            3'd2: begin q_d = {q_q[N-1], q_q[N-1:1]};    sout_d = q_q[0];   end
            3'd3: begin q_d = {q_q[0], q_q[N-1:1]};      sout_d = q_q[0];   end
            3'd4: begin q_d = {q_q[N-2:0], q_q[N-1]};    sout_d = q_q[N-1]; end
            3'd5: begin q_d = {sin, q_q[N-1:1]};         sout_d = q_q[0];   end
            3'd6: begin q_d = {q_q[N-2:0], sin};         sout_d = q_q[N-1]; end
            default: begin q_d = q_q;                    sout_d = sout_q;   end
          endcase
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  assign q           = q_q;
  assign sout        = sout_q;
  assign done        = done_q;
  assign busy        = (state_q == SHIFT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq at N=8: directed operations, a cycle-level reference
// model compared every cycle, plus literal end-of-operation checks.
module tb_univ_shift_seq;

  localparam int N  = 8;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          en = 1'b1, load = 1'b0, start = 1'b0, sin = 1'b0;
  logic [N-1:0]  d = '0;
  logic [2:0]    mode = '0;
  logic [AW-1:0] amt = '0;
  logic [N-1:0]  q;
  logic          sout, busy, done, dbg_state;

  always #5 clk = ~clk;

  univ_shift_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .d(d), .start(start),
    .mode(mode), .amt(amt), .sin(sin), .q(q), .sout(sout), .busy(busy),
    .done(done), .dbg_state_o(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // ---------------- reference model ----------------
  int mq = 0, msout = 0, mbusy = 0, mdone = 0, rem = 0, mm = 0;

  // One step of operation md on value v (arithmetic on plain ints).
  task automatic step(input int md, input int v, input int s, input int so_in,
                      output int nv, output int so);
    nv = v; so = so_in;
    case (md)
      0: begin so = v & 1;    nv = v >> 1; end
      1: begin so = v >> 7;   nv = (v * 2) % 256; end
      2: begin so = v & 1;    nv = (v >> 1) + (v & 128); end
      3: begin so = v & 1;    nv = (v >> 1) + (v & 1) * 128; end
      4: begin so = v >> 7;   nv = (v * 2) % 256 + (v >> 7); end
      5: begin so = v & 1;    nv = (v >> 1) + s * 128; end
      6: begin so = v >> 7;   nv = (v * 2) % 256 + s; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    int nv, so;
    if (clr) begin
      mq = 0; msout = 0; mbusy = 0; mdone = 0; rem = 0;
    end else if (!en) begin
      mdone = 0;
    end else begin
      mdone = 0;
      if (mbusy == 0) begin
        if (load) mq = int'(d);
        else if (start) begin
          if (amt == 0) mdone = 1;
          else begin mbusy = 1; rem = int'(amt); mm = int'(mode); end
        end
      end else begin
        step(mm, mq, int'(sin), msout, nv, so);
        mq = nv; msout = so;
        rem = rem - 1;
        if (rem == 0) begin mbusy = 0; mdone = 1; end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_q", int'(q), mq);
      check("model_sout", int'(sout), msout);
      check("model_busy", int'(busy), mbusy);
      check("model_done", int'(done), mdone);
      check("model_state", int'(dbg_state), mbusy);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1; d = v; tick(); load = 1'b0;
  endtask

  // Start an operation and wait for done; en is dropped for stall_len cycles
  // starting at wait-cycle stall_at; sin follows sin_bits one bit per cycle.
  task automatic run_op(input logic [2:0] md, input logic [AW-1:0] a,
                        input int stall_at, input int stall_len,
                        input logic [7:0] sin_bits,
                        output int bcyc, output int dcyc);
    bit got;
    mode = md; amt = a; start = 1'b1; tick(); start = 1'b0;
    bcyc = 0; dcyc = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (busy) bcyc++;
      if (done) begin dcyc++; got = 1'b1; end
      else begin
        en  = !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_len);
        sin = (c < 8) ? sin_bits[c] : 1'b0;
        tick();
      end
    end
    en = 1'b1; sin = 1'b0;
    check("done_timeout", int'(got), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, dn;
    tick(); tick();
    clr = 1'b0;
    chk_on = 1'b1;

    // reset after load
    do_load(8'hA5);
    check("load_a5", int'(q), 8'hA5);
    clr = 1'b1; tick(); clr = 1'b0;
    check("rst_q", int'(q), 0);
    check("rst_sout", int'(sout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // clr mid-shift aborts
    do_load(8'hB4);
    mode = 3'd0; amt = 3'd5; start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("abort_q", int'(q), 0);
    check("abort_busy", int'(busy), 0);
    tick();
    check("abort_idle", int'(busy), 0);

    // logical / arithmetic shifts
    do_load(8'hB4);
    run_op(3'd0, 3'd3, -1, 0, 8'h00, b, dn);
    check("lsr_q", int'(q), 8'h16);
    check("lsr_sout", int'(sout), 1);
    check("lsr_busy_cycles", b, 3);
    check("lsr_done_pulses", dn, 1);
    tick();
    check("lsr_done_drop", int'(done), 0);

    do_load(8'hB4);
    run_op(3'd2, 3'd3, -1, 0, 8'h00, b, dn);
    check("asr_q", int'(q), 8'hF6);

    do_load(8'hB4);
    run_op(3'd1, 3'd2, -1, 0, 8'h00, b, dn);
    check("lsl_q", int'(q), 8'hD0);
    check("lsl_sout", int'(sout), 0);

    // rotates
    do_load(8'h81);
    run_op(3'd4, 3'd1, -1, 0, 8'h00, b, dn);
    check("rol_q", int'(q), 8'h03);
    check("rol_sout", int'(sout), 1);
    do_load(8'h81);
    run_op(3'd3, 3'd7, -1, 0, 8'h00, b, dn);
    check("ror7_q", int'(q), 8'h03);
    run_op(3'd3, 3'd1, -1, 0, 8'h00, b, dn);
    check("ror1_q", int'(q), 8'h81);

    // serial in, sin = 1,0,1,1 on successive steps
    do_load(8'h00);
    run_op(3'd5, 3'd4, -1, 0, 8'b1101, b, dn);
    check("sir_q", int'(q), 8'hD0);
    do_load(8'h00);
    run_op(3'd6, 3'd4, -1, 0, 8'b1101, b, dn);
    check("sil_q", int'(q), 8'h0B);

    // reserved mode: no-op on q, still completes
    do_load(8'h5A);
    run_op(3'd7, 3'd3, -1, 0, 8'h00, b, dn);
    check("rsv_q", int'(q), 8'h5A);
    check("rsv_busy_cycles", b, 3);

    // stall: en low for 2 cycles mid-shift
    do_load(8'h81);
    run_op(3'd4, 3'd2, 1, 2, 8'h00, b, dn);
    check("stall_q", int'(q), 8'h06);
    check("stall_busy_cycles", b, 4);

    // load/start while busy are ignored and not queued
    do_load(8'h81);
    mode = 3'd4; amt = 3'd2; start = 1'b1; tick();
    load = 1'b1; d = 8'hFF; mode = 3'd0; amt = 3'd5; tick();
    load = 1'b0; start = 1'b0; tick();
    check("busy_ign_q", int'(q), 8'h06);
    check("busy_ign_done", int'(done), 1);
    tick();
    check("busy_ign_noqueue", int'(busy), 0);

    // load + start together: load wins
    load = 1'b1; d = 8'h3C; start = 1'b1; mode = 3'd0; amt = 3'd3; tick();
    load = 1'b0; start = 1'b0;
    check("ldst_q", int'(q), 8'h3C);
    check("ldst_busy", int'(busy), 0);
    tick();
    check("ldst_busy2", int'(busy), 0);

    // zero amount, then back-to-back start in the done cycle
    run_op(3'd4, 3'd0, -1, 0, 8'h00, b, dn);
    check("zero_busy_cycles", b, 0);
    check("zero_q", int'(q), 8'h3C);
    run_op(3'd4, 3'd1, -1, 0, 8'h00, b, dn);
    check("b2b_q", int'(q), 8'h78);
    check("b2b_busy_cycles", b, 1);

    tick(); tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
